stepper_phase_decoder: RTL and testbench
========================================

# stepper_phase_decoder

Receive-side monitor for the stepper coil interface. Samples the 4-bit coil phase word produced by the motor driver path, decodes it against the legal full-step and half-step sequences, and tracks shaft position, direction, step period and sequence faults. Sits beside the driver as a closed-loop checker and position source for display/diagnostics logic; it consumes exactly the phase word the driver emits.

## Interface
Parameters:
- POS_W, 16, width of signed position counter (half-step units)
- PER_W, 20, width of step-period counter (clk cycles)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock, asynchronous, active-high
- phase_in  input  4  coil phase word, same clock domain as clk
- clr  input  1  synchronous clear of position, period and fault
- position  output  POS_W  signed shaft position in half-steps
- dir  output  1  direction of last step (1 = forward)
- step_strobe  output  1  one-cycle pulse per decoded step
- period  output  PER_W  clk cycles between the last two steps
- period_valid  output  1  period holds a real measurement
- energized  output  1  coils currently driven (phase ≠ 0000)
- fault  output  1  sticky illegal-sequence flag

## Operation
- Phase index map (half-step order): 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001. Full-step (wave) uses even indices only. 0000 = de-energized. All other patterns illegal.
- phase_in registered into phase_q; decode of phase_q is combinational (valid, idx[2:0]).
- Delta = (idx − ref_idx) mod 8, 3-bit wrap arithmetic. 0 = no step; 1 or 2 = forward; 7 or 6 = reverse; 3, 4, 5 = fault. Position adds +delta (forward) or −(8−delta) (reverse); two's-complement wrap at POS_W, no saturation.
- FSM:
  - IDLE: phase_q = 0000 stays; legal pattern → TRACK, ref_idx ← idx, no step counted, period_valid unchanged, cycle counter cleared.
  - TRACK: legal delta ≠ 0 → step (position, dir, strobe, ref_idx update); phase_q = 0000 → IDLE (position/dir retained); illegal pattern or delta 3/4/5 → FAULT, fault ← 1, position frozen.
  - FAULT: ignores phase_q; clr → IDLE.
- Period: cycle counter increments every clk in TRACK, saturates at all-ones. On step: period ← counter+1 (saturating), counter ← 0. First step after entering TRACK does not update period; subsequent steps set period_valid ← 1.
- clr: position ← 0, period ← 0, period_valid ← 0, fault ← 0, counter ← 0. If in FAULT → IDLE. If a step is decoded the same cycle, clr wins: strobe suppressed, position 0, but ref_idx still takes the new index.
- energized = (phase_q ≠ 0000), registered.

## Timing
- Reset values: position 0, dir 0, step_strobe 0, period 0, period_valid 0, energized 0, fault 0; FSM IDLE; phase_q 0000.
- Latency: phase_in change sampled at edge N; position/dir/step_strobe/fault/energized update at edge N+1. step_strobe high for exactly one cycle per step.
- Phase changes may occur every cycle; each legal change yields one strobe. Back-to-back steps give period 1.
- Reset asserted mid-operation returns all state to reset values immediately.

## Structure
- Package stepper_phase_pkg: the eight phase pattern constants, PH_OFF = 4'b0000, FSM state typedef (IDLE, TRACK, FAULT). Shared with the driver.
- Sub-module phase_lut: combinational phase word → {valid, idx[2:0]}.
- Top holds FSM, position accumulator, period counter.

## Test plan
- Half-step forward: 1000,1100,0100,0110,0010,0011,0001,1001,1000 one pattern every 10 cycles -> 8 strobes, position = 8, dir = 1, period = 10, period_valid = 1.
- Full-step reverse: 1000,0001,0010,0100,1000 -> 4 strobes, position = −8, dir = 0, no fault.
- Illegal jump 1000→0010 and, separately, pattern 1010 -> fault = 1 next cycle, position frozen; clr -> fault = 0, position = 0, FSM IDLE.
- De-energize: forward 3 half-steps, 0000, then 0100 -> energized drops, position stays 3, re-entry counts no step, period_valid unchanged.
- Wrap and saturation: POS_W = 4, 9 forward half-steps from 0 -> position = −7; no steps for 2^PER_W cycles then step -> period = all-ones.
- Simultaneous clr and step, plus rst asserted mid-sequence -> position 0, no strobe; rst returns every output to reset value asynchronously.

Source files
------------

// File: rtl/stepper_phase_pkg.sv
// Shared coil phase encoding for the stepper driver and its receive-side monitor.
// Pattern constants are listed in half-step order; the wave sequence uses the even entries.
package stepper_phase_pkg;

  localparam logic [3:0] PH_0   = 4'b1000;
  localparam logic [3:0] PH_1   = 4'b1100;
  localparam logic [3:0] PH_2   = 4'b0100;
  localparam logic [3:0] PH_3   = 4'b0110;
  localparam logic [3:0] PH_4   = 4'b0010;
  localparam logic [3:0] PH_5   = 4'b0011;
  localparam logic [3:0] PH_6   = 4'b0001;
  localparam logic [3:0] PH_7   = 4'b1001;
  localparam logic [3:0] PH_OFF = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/phase_lut.sv
// Coil phase word to half-step index. De-energized and unlisted patterns decode as not valid.
module phase_lut
  import stepper_phase_pkg::*;
(
  input  logic [3:0] phase,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = 1'b1;
    idx   = 3'd0;
    case (phase)
      PH_0:    idx = 3'd0;
      PH_1:    idx = 3'd1;
      PH_2:    idx = 3'd2;
      PH_3:    idx = 3'd3;
      PH_4:    idx = 3'd4;
      PH_5:    idx = 3'd5;
      PH_6:    idx = 3'd6;
      PH_7:    idx = 3'd7;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Closed-loop monitor of the stepper coil phase word: position, direction, step period, faults.
//
// state | meaning
// IDLE  | coils off (or just cleared); first legal pattern sets the reference, no step counted
// TRACK | following the sequence; each legal index change is one step
// FAULT | illegal pattern or jump seen; position frozen until clr
module stepper_phase_decoder
  import stepper_phase_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int PER_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       phase_in,
  input  logic             clr,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             step_strobe,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             energized,
  output logic             fault
);

  state_e           state, state_nxt;
  logic [3:0]       phase_q;
  logic             lut_valid;
  logic [2:0]       lut_idx;
  logic [2:0]       ref_idx;
  logic [2:0]       delta;
  logic             is_off;
  logic             delta_bad;
  logic             take_ref;
  logic             do_step;
  logic             enter_track;
  logic             set_fault;
  logic             first_pending;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cnt_inc;
  logic [POS_W-1:0] step_delta;

  phase_lut u_lut (
    .phase (phase_q),
    .valid (lut_valid),
    .idx   (lut_idx)
  );

  assign is_off    = (phase_q == PH_OFF);
  assign delta     = lut_idx - ref_idx;
  assign delta_bad = (delta == 3'd3) || (delta == 3'd4) || (delta == 3'd5);
  // Deltas 6/7 read as -2/-1 once sign-extended, which is exactly the reverse step size.
  assign step_delta = {{(POS_W-3){delta[2]}}, delta};
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + PER_W'(1);

  always_comb begin
    state_nxt   = state;
    take_ref    = 1'b0;
    do_step     = 1'b0;
    enter_track = 1'b0;
    set_fault   = 1'b0;
    case (state)
      IDLE: begin
        if (lut_valid) begin
          state_nxt   = TRACK;
          take_ref    = 1'b1;
          enter_track = 1'b1;
        end else if (!is_off) begin
          state_nxt = FAULT;
          set_fault = 1'b1;
        end
      end
      TRACK: begin
        if (is_off) begin
          state_nxt = IDLE;
        end else if (!lut_valid || delta_bad) begin
          state_nxt = FAULT;
          set_fault = 1'b1;
        end else if (delta != 3'd0) begin
          do_step  = 1'b1;
          take_ref = 1'b1;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
    // clr dominates any fault detected in the same cycle.
    if (clr) begin
      set_fault = 1'b0;
      if (state_nxt == FAULT) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase_q       <= PH_OFF;
      ref_idx       <= 3'd0;
      position      <= '0;
      dir           <= 1'b0;
      step_strobe   <= 1'b0;
      period        <= '0;
      period_valid  <= 1'b0;
      energized     <= 1'b0;
      fault         <= 1'b0;
      cnt           <= '0;
      first_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_q     <= phase_in;
      energized   <= !is_off;
      step_strobe <= 1'b0;

      if (take_ref) ref_idx <= lut_idx;
      if (set_fault) fault <= 1'b1;

      if (enter_track || do_step) begin
        cnt <= '0;
      end else if (state == TRACK) begin
        cnt <= cnt_inc;
      end

      if (enter_track) first_pending <= 1'b1;

      if (do_step) begin
        position      <= position + step_delta;
        dir           <= ~delta[2];
        step_strobe   <= 1'b1;
        first_pending <= 1'b0;
        if (!first_pending) begin
          period       <= cnt_inc;
          period_valid <= 1'b1;
        end
      end

      // Placed last so it overrides a step decoded in the same cycle.
      if (clr) begin
        position     <= '0;
        period       <= '0;
        period_valid <= 1'b0;
        fault        <= 1'b0;
        cnt          <= '0;
        step_strobe  <= 1'b0;
        dir          <= dir;
      end
    end
  end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder: default-width instance plus a narrow one for wrap/saturation.
module tb_stepper_phase_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  phase_in = 4'b0000;

  logic [15:0] position;
  logic        dir, step_strobe, period_valid, energized, fault;
  logic [19:0] period;

  logic [3:0]  s_position;
  logic        s_dir, s_strobe, s_pv, s_en, s_fault;
  logic [3:0]  s_period;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;
  int n0;

  logic [3:0] half_seq [9] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010,
                               4'b0011, 4'b0001, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  stepper_phase_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .phase_in     (phase_in),
    .clr          (clr),
    .position     (position),
    .dir          (dir),
    .step_strobe  (step_strobe),
    .period       (period),
    .period_valid (period_valid),
    .energized    (energized),
    .fault        (fault)
  );

  stepper_phase_decoder #(.POS_W(4), .PER_W(4)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .phase_in     (phase_in),
    .clr          (clr),
    .position     (s_position),
    .dir          (s_dir),
    .step_strobe  (s_strobe),
    .period       (s_period),
    .period_valid (s_pv),
    .energized    (s_en),
    .fault        (s_fault)
  );

  always @(negedge clk) if (step_strobe) n_strobe <= n_strobe + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    phase_in = p;
    tick(n);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_pos", position, 0);
    check("rst_dir", dir, 0);
    check("rst_strobe", step_strobe, 0);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_en", energized, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    tick(2);

    // half-step forward, 10 cycles per pattern
    n0 = n_strobe;
    hold(half_seq[0], 10);
    for (int i = 1; i < 9; i++) begin
      phase_in = half_seq[i];
      if (i == 1) begin
        tick(1);
        check("lat_sample", step_strobe, 0);
        tick(1);
        check("lat_strobe", step_strobe, 1);
        tick(1);
        check("lat_one_cycle", step_strobe, 0);
        tick(7);
      end else begin
        tick(10);
      end
    end
    check("fwd_strobes", n_strobe - n0, 8);
    check("fwd_pos", position, 8);
    check("fwd_dir", dir, 1);
    check("fwd_period", period, 10);
    check("fwd_pv", period_valid, 1);
    check("fwd_en", energized, 1);

    pulse_clr();
    check("clr_pos", position, 0);
    check("clr_period", period, 0);
    check("clr_pv", period_valid, 0);

    // full-step reverse
    n0 = n_strobe;
    hold(4'b0001, 5);
    hold(4'b0010, 5);
    hold(4'b0100, 5);
    hold(4'b1000, 5);
    check("rev_strobes", n_strobe - n0, 4);
    check("rev_pos", position, 32'h0000_FFF8);
    check("rev_dir", dir, 0);
    check("rev_fault", fault, 0);

    // illegal jump 1000 -> 0010
    n0 = n_strobe;
    phase_in = 4'b0010;
    tick(1);
    check("jump_fault_early", fault, 0);
    tick(1);
    check("jump_fault", fault, 1);
    check("jump_pos", position, 32'h0000_FFF8);
    hold(4'b0100, 3);
    check("fault_ignores_pos", position, 32'h0000_FFF8);
    check("fault_ignores_strobes", n_strobe - n0, 0);
    pulse_clr();
    check("jump_clr_fault", fault, 0);
    check("jump_clr_pos", position, 0);
    hold(4'b0100, 2);
    hold(4'b0110, 3);
    check("after_idle_pos", position, 1);
    check("after_idle_strobes", n_strobe - n0, 1);

    // illegal pattern 1010
    phase_in = 4'b1010;
    tick(2);
    check("bad_pat_fault", fault, 1);
    check("bad_pat_pos", position, 1);
    hold(4'b0000, 2);
    pulse_clr();
    check("bad_clr_fault", fault, 0);
    check("bad_clr_pos", position, 0);
    check("bad_clr_en", energized, 0);

    // de-energize and re-entry
    hold(4'b1000, 6);
    hold(4'b1100, 6);
    hold(4'b0100, 6);
    hold(4'b0110, 6);
    check("deen_pos3", position, 3);
    check("deen_period", period, 6);
    check("deen_pv", period_valid, 1);
    phase_in = 4'b0000;
    tick(1);
    check("deen_en_lat", energized, 1);
    tick(2);
    check("deen_en_off", energized, 0);
    check("deen_pos_kept", position, 3);
    n0 = n_strobe;
    hold(4'b0100, 4);
    check("reentry_strobes", n_strobe - n0, 0);
    check("reentry_pos", position, 3);
    check("reentry_pv", period_valid, 1);
    check("reentry_en", energized, 1);
    hold(4'b0110, 4);
    check("reentry_step_pos", position, 4);
    check("reentry_first_period", period, 6);

    // wrap on the 4-bit instance, then period saturation
    hold(4'b0000, 2);
    pulse_clr();
    hold(4'b1000, 2);
    for (int k = 1; k < 9; k++) hold(half_seq[k], 2);
    hold(4'b1100, 40);
    check("wrap_small_pos", s_position, 4'b1001);
    check("wrap_main_pos", position, 9);
    hold(4'b0100, 4);
    check("sat_small_period", s_period, 4'hF);
    check("sat_main_period", period, 40);
    check("sat_main_pos", position, 10);

    // clr coinciding with a step
    n0 = n_strobe;
    phase_in = 4'b0110;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(2);
    check("clrstep_pos", position, 0);
    check("clrstep_strobes", n_strobe - n0, 0);
    hold(4'b0010, 3);
    check("clrstep_ref_pos", position, 1);
    check("clrstep_ref_strobes", n_strobe - n0, 1);
    check("pre_rst_pv", period_valid, 1);

    // asynchronous reset mid-sequence
    phase_in = 4'b0011;
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("arst_pos", position, 0);
    check("arst_dir", dir, 0);
    check("arst_strobe", step_strobe, 0);
    check("arst_period", period, 0);
    check("arst_pv", period_valid, 0);
    check("arst_en", energized, 0);
    check("arst_fault", fault, 0);
    tick(2);
    check("arst_hold_pos", position, 0);
    rst = 1'b0;
    tick(3);
    check("post_rst_pos", position, 0);
    check("post_rst_en", energized, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
